// File: rtl/alu_issue_pkg.sv
// Shared RV32I subset constants and ALU operation codes for the issue stage,
// the ALU and their benches.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BYTE    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SRA = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_BNE = 4'b0111,
    ALU_LUI = 4'b1000
  } alu_sel_e;

  // One decoded instruction as held by the issue register.
  typedef struct packed {
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    alu_sel_e    alu_sel;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  mem_size;
    logic [31:0] imm_out;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one RV32I instruction word into an issue entry.
// Unsupported encodings produce an all-zero entry with illegal set.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t entry
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] shamt;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign shamt  = {27'd0, instr[24:20]};

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // one unassigned; a missing default here would infer latches.
    entry = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        entry.alu_in1   = rs1_data;
        entry.alu_in2   = rs2_data;
        entry.reg_write = 1'b1;
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          entry.alu_sel = ALU_ADD;
          legal         = 1'b1;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
          entry.alu_sel = ALU_SUB;
          legal         = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        entry.alu_in1   = rs1_data;
        entry.reg_write = 1'b1;
        case (funct3)
          F3_ADD_SUB: begin entry.alu_sel = ALU_ADD; entry.alu_in2 = imm_i; legal = 1'b1; end
          F3_AND:     begin entry.alu_sel = ALU_AND; entry.alu_in2 = imm_i; legal = 1'b1; end
          F3_XOR:     begin entry.alu_sel = ALU_XOR; entry.alu_in2 = imm_i; legal = 1'b1; end
          F3_SLL: begin
            entry.alu_in2 = shamt;
            if (funct7 == F7_BASE) begin
              entry.alu_sel = ALU_SLL;
              legal         = 1'b1;
            end
          end
          F3_SRL_SRA: begin
            entry.alu_in2 = shamt;
            if (funct7 == F7_BASE) begin
              entry.alu_sel = ALU_SRL;
              legal         = 1'b1;
            end else if (funct7 == F7_ALT) begin
              entry.alu_sel = ALU_SRA;
              legal         = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD) begin
          entry.alu_sel   = ALU_ADD;
          entry.alu_in1   = rs1_data;
          entry.alu_in2   = imm_i;
          entry.mem_read  = 1'b1;
          entry.reg_write = 1'b1;
          entry.mem_size  = MEM_WORD;
          legal           = 1'b1;
        end
      end
      OPC_STORE: begin
        entry.alu_sel   = ALU_ADD;
        entry.alu_in1   = rs1_data;
        entry.alu_in2   = imm_s;
        entry.mem_write = 1'b1;
        entry.imm_out   = imm_s;
        case (funct3)
          F3_WORD: begin entry.mem_size = MEM_WORD; legal = 1'b1; end
          F3_BYTE: begin entry.mem_size = MEM_BYTE; legal = 1'b1; end
          default: ;
        endcase
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BNE) begin
          entry.alu_sel = ALU_BNE;
          entry.alu_in1 = rs1_data;
          entry.alu_in2 = rs2_data;
          entry.branch  = 1'b1;
          entry.imm_out = imm_b;
          legal         = 1'b1;
        end
      end
      OPC_LUI: begin
        entry.alu_sel   = ALU_LUI;
        entry.alu_in2   = {12'd0, instr[31:12]};
        entry.reg_write = 1'b1;
        legal           = 1'b1;
      end
      default: ;
    endcase

    if (!legal) begin
      entry         = '0;
      entry.illegal = 1'b1;
    end
    // A non-writing instruction never names a destination.
    entry.rd = entry.reg_write ? instr[11:7] : 5'd0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry issue register between decode and the ALU with a
// valid/ready handshake on both sides, flush, and a sticky illegal flag.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_sel,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic [1:0]  mem_size,
  output logic [31:0] imm_out,
  output logic        illegal,
  output logic        illegal_seen
);

  issue_entry_t dec_entry;
  issue_entry_t held;
  logic         valid_q;
  logic         seen_q;
  logic         fill;

  alu_issue_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .entry    (dec_entry)
  );

  // Ready while empty or while the held entry leaves this cycle.
  assign in_ready = !valid_q || out_ready;
  assign fill     = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the held entry is a single register, not a memory, so it is
      // reset with the flags and every output reads 0 during reset.
      valid_q <= 1'b0;
      held    <= '0;
      seen_q  <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignments throughout, so every update here sees
      // the pre-edge values regardless of statement order.
      valid_q <= 1'b0;
      held    <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      held    <= dec_entry;
      if (dec_entry.illegal) seen_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign alu_in1      = held.alu_in1;
  assign alu_in2      = held.alu_in2;
  assign alu_sel      = held.alu_sel;
  assign rd           = held.rd;
  assign reg_write    = held.reg_write;
  assign mem_read     = held.mem_read;
  assign mem_write    = held.mem_write;
  assign branch       = held.branch;
  assign mem_size     = held.mem_size;
  assign imm_out      = held.imm_out;
  assign illegal      = held.illegal;
  assign illegal_seen = seen_q;

endmodule
